// File: rtl/l2_pri_bank_arbiter_pkg.sv
// Shared types and width helpers for the L2 private-bank arbiter and its
// round-robin selector.
package l2_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NB_MASTERS_DFLT = 4;
  localparam int LOCK_MAX_DFLT   = 8;

  // Index width for a given number of requesters (at least one bit)
  function automatic int idx_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value lock_max itself
  function automatic int cnt_w_of(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

  localparam int IDX_W = idx_w_of(NB_MASTERS_DFLT);
  localparam int CNT_W = cnt_w_of(LOCK_MAX_DFLT);

endpackage

// File: rtl/l2_pri_bank_arbiter_rr_prio_select.sv
// Find-first-set over a request vector, starting at a rotating pointer and
// searching upward with wrap-around. Purely combinational.
module rr_prio_select
  import l2_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  localparam int SW = IW + 1;

  // Walk the candidates ptr, ptr+1, ... (mod N); the first requester wins
  always_comb begin
    logic [SW-1:0] sum;
    logic [IW-1:0] cand;
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + SW'(i);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end else begin
        sum = sum;
      end
      cand = sum[IW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/l2_pri_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported, 1-cycle-latency L2 private
// bank among NB_MASTERS requesters, with bounded per-master lock for atomic
// sequences. Grants are combinational; responses come back one cycle later.
module l2_pri_bank_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NB_MASTERS = NB_MASTERS_DFLT,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = LOCK_MAX_DFLT
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_MASTERS-1:0]            req_i,
  input  logic [NB_MASTERS-1:0]            lock_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
  input  logic [NB_MASTERS-1:0]            wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
  output logic [NB_MASTERS-1:0]            gnt_o,
  output logic [NB_MASTERS-1:0]            r_valid_o,
  output logic [NB_MASTERS*DATA_WIDTH-1:0] r_rdata_o,
  output logic [NB_MASTERS-1:0]            r_opc_o,
  output logic                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]            mem_add_o,
  output logic                             mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  localparam int IW = idx_w_of(NB_MASTERS);
  localparam int CW = cnt_w_of(LOCK_MAX);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NB_MASTERS - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_vld_q, resp_vld_d;
  logic [IW-1:0] resp_sel_q, resp_sel_d;

  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic          lock_cont;
  logic          win_valid;
  logic [IW-1:0] win_idx;

  rr_prio_select #(
    .N  (NB_MASTERS),
    .IW (IW)
  ) u_rr_prio_select (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Choose this cycle's winner: a live, unexpired lock beats round-robin
  always_comb begin
    lock_cont = 1'b0;
    win_valid = 1'b0;
    win_idx   = '0;
    if (rst_i) begin
      win_valid = 1'b0;
    end else if ((state_q == LOCKED) && req_i[owner_q] && (cnt_q < LOCK_MAX_C)) begin
      lock_cont = 1'b1;
      win_valid = 1'b1;
      win_idx   = owner_q;
    end else begin
      win_valid = sel_valid;
      win_idx   = sel_idx;
    end
  end

  // Next-state: lock bookkeeping, pointer rotation and response tracking
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    resp_vld_d = win_valid;
    resp_sel_d = win_idx;
    if (lock_cont) begin
      // ptr already points past the owner, so it stays put
      if (lock_i[owner_q]) begin
        state_d = LOCKED;
        cnt_d   = cnt_q + CW'(1);
      end else begin
        state_d = ARB;
        cnt_d   = '0;
      end
    end else if (win_valid) begin
      ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
      if (lock_i[win_idx]) begin
        state_d = LOCKED;
        owner_d = win_idx;
        cnt_d   = CW'(1);
      end else begin
        state_d = ARB;
        cnt_d   = '0;
      end
    end else begin
      // Nobody requesting: hold everything
      state_d = state_q;
    end
  end

  // Grant and bank request, muxed from the winner
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = win_valid;
    mem_add_o   = add_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    mem_wen_o   = wen_i[win_idx];
    mem_be_o    = be_i[int'(win_idx)*BW +: BW];
    mem_wdata_o = wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    if (win_valid) begin
      gnt_o[win_idx] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

  // Route the bank response to the master granted in the previous cycle
  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    if (resp_vld_q && !rst_i) begin
      r_valid_o[resp_sel_q]                                 = 1'b1;
      r_rdata_o[int'(resp_sel_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
    end else begin
      r_valid_o = '0;
    end
  end

  assign r_opc_o = '0;

  // Arbitration state, pointer and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      owner_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_sel_q <= resp_sel_d;
    end
  end

endmodule

// File: doc/l2_pri_bank_arbiter.md
# l2_pri_bank_arbiter

Round-robin arbiter that shares one single-ported, 1-cycle-latency L2 private bank among `NB_MASTERS` TCDM requesters. It sits between the SoC interconnect master ports and a private bank's slave port. It drives the bank with the bank's fixed `gnt = req` handshake and routes each response back to the master that issued it. Optional per-master lock gives bounded atomic sequences (e.g. read-modify-write, CFI shadow-stack push).

## Interface
- `NB_MASTERS`, 4, number of requesters (2..16)
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8`
- `LOCK_MAX`, 8, maximum consecutive locked grants to one owner (>=1)

Ports:
- `clk_i` in 1: clock; single clock domain
- `rst_i` in 1: synchronous, active-high reset
- `req_i` in NB_MASTERS: per-master request
- `lock_i` in NB_MASTERS: per-master lock request, sampled only with a grant
- `add_i` in NB_MASTERS×ADDR_WIDTH: byte address
- `wen_i` in NB_MASTERS: 1 = read, 0 = write
- `be_i` in NB_MASTERS×DATA_WIDTH/8: byte enables
- `wdata_i` in NB_MASTERS×DATA_WIDTH: write data
- `gnt_o` out NB_MASTERS: grant, one-hot or zero
- `r_valid_o` out NB_MASTERS: response valid, one-hot or zero
- `r_rdata_o` out NB_MASTERS×DATA_WIDTH: read data, zero for non-target masters
- `r_opc_o` out NB_MASTERS: constant 0
- `mem_req_o` out 1; `mem_add_o` out ADDR_WIDTH; `mem_wen_o` out 1; `mem_be_o` out DATA_WIDTH/8; `mem_wdata_o` out DATA_WIDTH: bank request, muxed from the winner
- `mem_rdata_i` in DATA_WIDTH: bank read data, valid 1 cycle after `mem_req_o`

## Operation
- States: ARB, LOCKED(owner, cnt).
- **ARB**
  - Winner = first requesting master at or after `ptr`, searching upward with wrap.
  - `gnt_o[winner]` = 1; `mem_*` = winner's fields; `ptr` <= winner+1 mod NB_MASTERS.
  - If `lock_i[winner]` = 1: go to LOCKED with owner = winner, cnt = 1.
  - No request: `mem_req_o` = 0; state and `ptr` are held.
- **LOCKED**
  - If `req_i[owner]` and cnt < LOCK_MAX:
    - Grant owner only; cnt++.
    - Stay LOCKED if `lock_i[owner]`, else go to ARB.
    - Other masters see `gnt_o` = 0.
    - `ptr` is unchanged (already owner+1).
  - If `!req_i[owner]` or cnt == LOCK_MAX:
    - Perform a normal ARB selection in the same cycle; no idle bubble.
    - Next state follows the ARB rules.
    - The owner has lowest priority and can relock only if it is the sole requester.
- **Response path**
  - `resp_sel` <= winner index and `resp_vld` <= `mem_req_o`, each cycle.
  - `r_valid_o[resp_sel]` = `resp_vld`; this applies to reads and writes.
  - `r_rdata_o[resp_sel]` = `mem_rdata_i`; all other lanes are 0.
- Addresses pass through unmodified; offset removal is the bank's job.
- `gnt_o` never depends on `r_valid_o`. Back-to-back grants to different masters occur every cycle.

## Timing
- Grant is combinational: same cycle as `req_i`. Bank request is issued in that cycle.
- Response is exactly 1 cycle after the grant. Throughput is 1 access per cycle.
- Reset values:
  - `ptr` = 0, state = ARB, cnt = 0
  - `resp_vld` = 0, `resp_sel` = 0
  - All `r_valid_o` = 0, `r_rdata_o` = 0, `r_opc_o` = 0
- During reset, `gnt_o` = 0 and `mem_req_o` = 0, even with requests pending.
- Reset asserted mid-lock:
  - Next cycle is ARB with `ptr` = 0.
  - A response pending from the pre-reset grant is dropped; `r_valid_o` stays 0.
- A request withdrawn without grant is legal and leaves no state.
- Worst-case wait for an unlocked master: (NB_MASTERS-1)×LOCK_MAX cycles.

## Structure
- Package `l2_arb_pkg`:
  - `arb_state_e` enum {ARB, LOCKED}
  - Width constants `IDX_W = $clog2(NB_MASTERS)` and `CNT_W = $clog2(LOCK_MAX+1)`
- Sub-module `rr_prio_select`: combinational find-first-set from a rotating pointer. Inputs are req vector and ptr; outputs are a valid flag and the index. It is reused by other SoC arbiters.

## Test plan
- **Single master.** Master 2 reads 0x1C010008, then writes the same address with be=4'b0011 and data 0xAABBCCDD, then reads again.
  - `gnt_o[2]` is given in the same cycle as each request.
  - `r_valid_o[2]` follows one cycle later each time.
  - The final read returns `mem_rdata_i` with bytes 0–1 updated.
- **Full contention.** All 4 masters request continuously for 8 cycles after reset.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `r_valid_o` follows the same order shifted by 1 cycle.
- **Lock expiry.** Master 1 holds req+lock for 12 cycles; masters 0 and 3 request continuously.
  - Master 1 is granted for 8 cycles (LOCK_MAX).
  - Then master 3 is granted, then master 0.
  - Master 1 is next granted only after both.
- **Lock release.** Master 1 drops lock with req still high after 3 grants.
  - Its 4th grant is unlocked and returns the state to ARB.
  - Arbitration then resumes from `ptr` = 2.
- **Reset during lock.** Assert `rst_i` on the cycle after master 0's locked grant.
  - The pending `r_valid_o[0]` never asserts.
  - Post-reset contention between masters 0 and 3 grants master 0 first.
- **Idle cycles.** Insert idle cycles between requests.
  - `mem_req_o` = 0 and `r_valid_o` = 0 on the following cycle.
  - `ptr` is unchanged across idle cycles.
